wheel_setpoint_ramp: RTL and testbench
======================================

Name: wheel_setpoint_ramp

Overview:
- Slew-rate limiter and command watchdog in front of each wheel controller's target-speed input.
- Accepts a commanded wheel angular velocity from the motion planner through a valid/ready handshake.
- On each 167 ms control tick, steps its output toward that command by at most one STEP, passing through zero on direction reversal.
- Forces the output to zero if commands stop arriving.

Parameters:
- N_WIDTH, 17, word width; sign-magnitude, bit N_WIDTH-1 = sign (1 = negative), bits N_WIDTH-2:0 = unsigned magnitude, Q8.8 rad/s.
- STEP, 128, maximum magnitude change per tick (128 = 0.5 rad/s).
- WDOG_TICKS, 6, number of ticks without an accepted command before forced stop (about 1 s).
- MAX_MAG, 5120, magnitude clamp (20.0 rad/s); used only with the optional feature.

Ports:
- WHEEL_SETPOINT_RAMP_CLOCK  in  1  system clock.
- WHEEL_SETPOINT_RAMP_RESET_InHigh  in  1  reset; synchronous, active-high.
- WHEEL_SETPOINT_RAMP_TICK_In  in  1  one-cycle active-high strobe, once per 167 ms control period.
- WHEEL_SETPOINT_RAMP_CMDW_InBus  in  N_WIDTH  commanded angular velocity.
- WHEEL_SETPOINT_RAMP_CMDVALID_In  in  1  command valid.
- WHEEL_SETPOINT_RAMP_CMDREADY_Out  out  1  command ready.
- WHEEL_SETPOINT_RAMP_W_OutBus  out  N_WIDTH  ramped target; drives the wheel controller TARGETW input.
- WHEEL_SETPOINT_RAMP_SETTLED_Out  out  1  output equals the active target.
- WHEEL_SETPOINT_RAMP_WDOG_Out  out  1  watchdog stop active.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: W_OutBus = 0, SETTLED = 1, WDOG = 0, internal target = 0, watchdog counter = 0, state IDLE.
- Ready: CMDREADY = ~TICK_In & ~RESET_InHigh (combinational).
- Accept: a command is accepted when VALID & READY. The target register loads it at the next edge and the watchdog counter clears.
- Canonical zero: -0 on input is stored as +0. Zero magnitude is always output with sign 0.
- Latency: the output changes only at the edge following a tick, so it lags the tick by 1 cycle. A command accepted in cycle c affects the first tick occurring after c; since ticks are never accepted-cycles, there is no same-cycle race.
- Tick update, with cur = output magnitude, tgt = target magnitude:
  - Same sign, or cur == 0: cur moves toward tgt by min(STEP, |tgt - cur|). When cur was 0, the sign takes the target sign.
  - Sign differs and cur > 0: cur = max(cur - STEP, 0); the sign is kept until cur reaches 0. A reversal therefore always lands on exactly 0 for at least one tick.
- Arithmetic: magnitude arithmetic is N_WIDTH-1 bits unsigned; the step never overshoots tgt or underflows 0.
- FSM states:
  - IDLE: output 0 and target 0.
  - RAMP: output != target.
  - HOLD: output == target != 0.
  - STOP: watchdog fired.
- FSM transitions, evaluated on registered values:
  - IDLE → RAMP on acceptance of a nonzero target.
  - RAMP → HOLD when output == target after an update.
  - RAMP → IDLE when both become 0.
  - HOLD → RAMP on a new differing target.
- Watchdog:
  - Counts ticks and saturates at WDOG_TICKS.
  - When it reaches WDOG_TICKS in any non-IDLE state: target forced to +0, state STOP, WDOG = 1. The output ramps down at STEP per tick.
  - STOP exits to RAMP on the next accepted command: WDOG clears and that command becomes the target.
  - STOP → IDLE when the output reaches 0 with no command accepted; WDOG stays 1 until a command is accepted.
  - In IDLE the counter is held at 0.
- SETTLED: registered; 1 when output == target, including after reset.
- Reset mid-ramp: everything returns to reset values at the next edge. A pending command is discarded.

Optional Feature:
- Macro: WHEEL_SETPOINT_RAMP_SATURATE_EN.
- Defined: accepted command magnitudes above MAX_MAG are stored as MAX_MAG with the sign kept.
- Undefined: commands are stored unmodified. MAX_MAG is unused.

Test Plan:
- Bench setup: tick every 10 cycles.
- Reset, then accept +2.0 (0x00200): W_OutBus = 0x00080, 0x00100, 0x00180, 0x00200 on successive ticks; SETTLED = 1 after the 4th tick; state HOLD.
- From +1.0 (0x00100) held, accept -1.0 (0x10100): outputs 0x00080, 0x00000, 0x10080, 0x10100; exactly one tick at 0.
- VALID asserted in the same cycle as TICK: READY = 0, command not accepted; accepted on the next cycle, applied at the following tick.
- Hold +1.0 with no further commands: after 6 ticks WDOG = 1, output drops 0x00080 then 0; a new command clears WDOG and the ramp resumes.
- Command +0.3 (0x0004D) from 0: reaches 0x0004D on the first tick with no overshoot; command -0 (0x10000) yields target +0 and W_OutBus = 0x00000.
- With WHEEL_SETPOINT_RAMP_SATURATE_EN defined, command +30.0 (0x01E00): target stored as 0x01400; output saturates at 0x01400 after 40 ticks.

Source files
------------

// File: rtl/wheel_setpoint_ramp.sv
// rtl/wheel_setpoint_ramp.sv - slew-rate limiter and command watchdog for one wheel target speed
//
// Purpose: accepts a commanded wheel angular velocity (sign-magnitude, Q8.8 rad/s)
// and, on each control tick, moves the output toward it by at most STEP. A reversal
// always passes through zero. If no command is accepted for WDOG_TICKS ticks, the
// output is ramped down to zero.
//
// Optional build macro: WHEEL_SETPOINT_RAMP_SATURATE_EN. When it is defined, accepted
// command magnitudes are clamped to MAX_MAG.
//
// Ports:
//   WHEEL_SETPOINT_RAMP_CLOCK         system clock
//   WHEEL_SETPOINT_RAMP_RESET_InHigh  synchronous active-high reset
//   WHEEL_SETPOINT_RAMP_TICK_In       one-cycle control-period strobe
//   WHEEL_SETPOINT_RAMP_CMDW_InBus    commanded velocity (bit N_WIDTH-1 = sign)
//   WHEEL_SETPOINT_RAMP_CMDVALID_In   command valid
//   WHEEL_SETPOINT_RAMP_CMDREADY_Out  command ready (low on tick cycles and in reset)
//   WHEEL_SETPOINT_RAMP_W_OutBus      ramped target velocity
//   WHEEL_SETPOINT_RAMP_SETTLED_Out   output equals the active target
//   WHEEL_SETPOINT_RAMP_WDOG_Out      watchdog stop active
module wheel_setpoint_ramp #(
   parameter int N_WIDTH    = 17,
   parameter int STEP       = 128,
   parameter int WDOG_TICKS = 6,
   parameter int MAX_MAG    = 5120
) (
   input  logic               WHEEL_SETPOINT_RAMP_CLOCK,
   input  logic               WHEEL_SETPOINT_RAMP_RESET_InHigh,
   input  logic               WHEEL_SETPOINT_RAMP_TICK_In,
   input  logic [N_WIDTH-1:0] WHEEL_SETPOINT_RAMP_CMDW_InBus,
   input  logic               WHEEL_SETPOINT_RAMP_CMDVALID_In,
   output logic               WHEEL_SETPOINT_RAMP_CMDREADY_Out,
   output logic [N_WIDTH-1:0] WHEEL_SETPOINT_RAMP_W_OutBus,
   output logic               WHEEL_SETPOINT_RAMP_SETTLED_Out,
   output logic               WHEEL_SETPOINT_RAMP_WDOG_Out
);
   localparam int MW = N_WIDTH - 1;
   localparam int CW = $clog2(WDOG_TICKS + 1);
   localparam logic [MW-1:0] STEP_M = MW'(STEP);
   localparam logic [CW-1:0] WDOG_M = CW'(WDOG_TICKS);

   typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

   state_t             state_q, state_d;
   logic [N_WIDTH-1:0] w_q, w_d;
   logic [N_WIDTH-1:0] tgt_q, tgt_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               settled_q, settled_d;
   logic               wdog_q, wdog_d;

   logic               accept;
   logic [MW-1:0]      cmd_mag;
   logic [N_WIDTH-1:0] cmd_word;
   logic [MW-1:0]      cur, tgt, diff, new_mag;
   logic               new_sign;
   logic [N_WIDTH-1:0] stepped;
   logic [CW-1:0]      cnt_inc;
   logic               fire;

   assign WHEEL_SETPOINT_RAMP_CMDREADY_Out = ~WHEEL_SETPOINT_RAMP_TICK_In & ~WHEEL_SETPOINT_RAMP_RESET_InHigh;
   assign accept = WHEEL_SETPOINT_RAMP_CMDVALID_In & WHEEL_SETPOINT_RAMP_CMDREADY_Out;

   // Command conditioning: optional clamp, then -0 is folded to +0.
   always_comb begin
      cmd_mag = WHEEL_SETPOINT_RAMP_CMDW_InBus[MW-1:0];
`ifdef WHEEL_SETPOINT_RAMP_SATURATE_EN
      if (cmd_mag > MW'(MAX_MAG)) cmd_mag = MW'(MAX_MAG);
`endif
      cmd_word = {WHEEL_SETPOINT_RAMP_CMDW_InBus[N_WIDTH-1] & (cmd_mag != '0), cmd_mag};
   end

   // One slew step of the output toward the current target.
   assign cur = w_q[MW-1:0];
   assign tgt = tgt_q[MW-1:0];

   always_comb begin
      diff     = '0;
      new_mag  = cur;
      new_sign = w_q[N_WIDTH-1];
      if ((w_q[N_WIDTH-1] == tgt_q[N_WIDTH-1]) || (cur == '0)) begin
         if (tgt > cur) begin
            diff    = tgt - cur;
            new_mag = cur + ((diff > STEP_M) ? STEP_M : diff);
         end else begin
            diff    = cur - tgt;
            new_mag = cur - ((diff > STEP_M) ? STEP_M : diff);
         end
         new_sign = tgt_q[N_WIDTH-1];
      end else begin
         // Opposite sign: shrink toward zero keeping the old sign, so a reversal
         // always spends at least one tick exactly at zero.
         new_mag = (cur > STEP_M) ? (cur - STEP_M) : '0;
      end
      stepped = {new_sign & (new_mag != '0), new_mag};
   end

   assign cnt_inc = (cnt_q == WDOG_M) ? cnt_q : (cnt_q + CW'(1));
   assign fire    = WHEEL_SETPOINT_RAMP_TICK_In && ((state_q == RAMP) || (state_q == HOLD)) && (cnt_inc == WDOG_M);

   always_comb begin
      w_d     = w_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      wdog_d  = wdog_q;
      state_d = state_q;

      if (accept) begin
         tgt_d  = cmd_word;
         cnt_d  = '0;
         wdog_d = 1'b0;
      end

      // On the tick that trips the watchdog the output still steps toward the
      // old target; the forced zero target takes effect from the next tick.
      if (WHEEL_SETPOINT_RAMP_TICK_In) begin
         w_d   = stepped;
         cnt_d = (state_q == IDLE) ? '0 : cnt_inc;
      end

      if (fire) begin
         tgt_d  = '0;
         wdog_d = 1'b1;
      end

      if (fire) begin
         state_d = STOP;
      end else begin
         case (state_q)
            IDLE:      if (accept && (cmd_mag != '0)) state_d = RAMP;
            RAMP,
            HOLD:      if (w_d == tgt_d) state_d = (tgt_d == '0) ? IDLE : HOLD;
                       else              state_d = RAMP;
            STOP:      if (accept)                    state_d = RAMP;
                       else if (w_d == '0)            state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end

      if (state_d == IDLE) cnt_d = '0;

      settled_d = (w_d == tgt_d);
   end

   always_ff @(posedge WHEEL_SETPOINT_RAMP_CLOCK) begin
      if (WHEEL_SETPOINT_RAMP_RESET_InHigh) begin
         state_q   <= IDLE;
         w_q       <= '0;
         tgt_q     <= '0;
         cnt_q     <= '0;
         settled_q <= 1'b1;
         wdog_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
         settled_q <= settled_d;
         wdog_q    <= wdog_d;
      end
   end

   assign WHEEL_SETPOINT_RAMP_W_OutBus    = w_q;
   assign WHEEL_SETPOINT_RAMP_SETTLED_Out = settled_q;
   assign WHEEL_SETPOINT_RAMP_WDOG_Out    = wdog_q;

endmodule

// File: tb/tb_wheel_setpoint_ramp.sv
// tb/tb_wheel_setpoint_ramp.sv - scoreboard bench for wheel_setpoint_ramp
module tb_wheel_setpoint_ramp;
   localparam int N = 17;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tick = 1'b0;
   logic [N-1:0] cmd = '0;
   logic         valid = 1'b0;
   logic         ready;
   logic [N-1:0] w;
   logic         settled;
   logic         wdog;

   int vectors = 0;
   int miscompares = 0;

   logic [N+1:0] exp_q[$];
   logic         tick_d = 1'b0;

   always #5 clk = ~clk;

   wheel_setpoint_ramp dut (
      .WHEEL_SETPOINT_RAMP_CLOCK        (clk),
      .WHEEL_SETPOINT_RAMP_RESET_InHigh (rst),
      .WHEEL_SETPOINT_RAMP_TICK_In      (tick),
      .WHEEL_SETPOINT_RAMP_CMDW_InBus   (cmd),
      .WHEEL_SETPOINT_RAMP_CMDVALID_In  (valid),
      .WHEEL_SETPOINT_RAMP_CMDREADY_Out (ready),
      .WHEEL_SETPOINT_RAMP_W_OutBus     (w),
      .WHEEL_SETPOINT_RAMP_SETTLED_Out  (settled),
      .WHEEL_SETPOINT_RAMP_WDOG_Out     (wdog)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Monitor: the output updates on the edge that samples a tick, so it is
   // compared on the following falling edge.
   always @(posedge clk) tick_d <= tick;

   always @(negedge clk) begin
      logic [N+1:0] e;
      if (tick_d) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("tick_out{w,settled,wdog}", 32'({w, settled, wdog}), 32'(e));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] c);
      cmd   = c;
      valid = 1'b1;
      #1;
      check("ready_idle", 32'(ready), 32'd1);
      cyc();
      valid = 1'b0;
   endtask

   // Tick roughly every 10 cycles; expected response queued at stimulus time.
   task automatic tick_exp(input logic [N-1:0] ew, input logic es, input logic ewd);
      repeat (9) cyc();
      exp_q.push_back({ew, es, ewd});
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] lim;
      int           nt;
      logic [N-1:0] ew;

      // Reset with a pending command, which must be discarded.
      valid = 1'b1;
      cmd   = 17'h00200;
      repeat (3) cyc();
      check("ready_in_reset", 32'(ready), 32'd0);
      valid = 1'b0;
      rst   = 1'b0;
      #1;
      check("reset_w", 32'(w), 32'd0);
      check("reset_settled", 32'(settled), 32'd1);
      check("reset_wdog", 32'(wdog), 32'd0);

      // Ramp up to +2.0.
      send(17'h00200);
      tick_exp(17'h00080, 1'b0, 1'b0);
      tick_exp(17'h00100, 1'b0, 1'b0);
      tick_exp(17'h00180, 1'b0, 1'b0);
      tick_exp(17'h00200, 1'b1, 1'b0);

      // Down to +1.0, then reverse to -1.0 through exactly one zero tick.
      send(17'h00100);
      tick_exp(17'h00180, 1'b0, 1'b0);
      tick_exp(17'h00100, 1'b1, 1'b0);
      send(17'h10100);
      tick_exp(17'h00080, 1'b0, 1'b0);
      tick_exp(17'h00000, 1'b0, 1'b0);
      tick_exp(17'h10080, 1'b0, 1'b0);
      tick_exp(17'h10100, 1'b1, 1'b0);

      // VALID during the tick cycle is refused, accepted the cycle after.
      repeat (9) cyc();
      exp_q.push_back({17'h10100, 1'b1, 1'b0});
      cmd   = 17'h00000;
      valid = 1'b1;
      tick  = 1'b1;
      #1;
      check("ready_on_tick", 32'(ready), 32'd0);
      cyc();
      tick = 1'b0;
      #1;
      check("ready_after_tick", 32'(ready), 32'd1);
      cyc();
      valid = 1'b0;
      tick_exp(17'h10080, 1'b0, 1'b0);
      tick_exp(17'h00000, 1'b1, 1'b0);

      // Watchdog: hold +1.0 with no commands, then recover from STOP.
      send(17'h00100);
      tick_exp(17'h00080, 1'b0, 1'b0);
      tick_exp(17'h00100, 1'b1, 1'b0);
      tick_exp(17'h00100, 1'b1, 1'b0);
      tick_exp(17'h00100, 1'b1, 1'b0);
      tick_exp(17'h00100, 1'b1, 1'b0);
      tick_exp(17'h00100, 1'b0, 1'b1);
      tick_exp(17'h00080, 1'b0, 1'b1);
      send(17'h00180);
      check("wdog_cleared_by_cmd", 32'(wdog), 32'd0);
      tick_exp(17'h00100, 1'b0, 1'b0);
      tick_exp(17'h00180, 1'b1, 1'b0);

      // Back to zero, small step without overshoot, -0 canonicalised.
      send(17'h00000);
      tick_exp(17'h00100, 1'b0, 1'b0);
      tick_exp(17'h00080, 1'b0, 1'b0);
      tick_exp(17'h00000, 1'b1, 1'b0);
      send(17'h0004D);
      tick_exp(17'h0004D, 1'b1, 1'b0);
      send(17'h10000);
      tick_exp(17'h00000, 1'b1, 1'b0);
      send(17'h10000);
      tick_exp(17'h00000, 1'b1, 1'b0);

      // Large command: clamped with the saturate build, raw otherwise.
`ifdef WHEEL_SETPOINT_RAMP_SATURATE_EN
      lim = 17'h01400;
`else
      lim = 17'h01E00;
`endif
      nt = int'(lim) / 128;
      send(17'h01E00);
      for (int k = 1; k <= nt; k++) begin
         if (k % 5 == 0) send(17'h01E00);
         ew = (k * 128 >= int'(lim)) ? lim : N'(k * 128);
         tick_exp(ew, (k * 128 >= int'(lim)), 1'b0);
      end

      // Reset mid-ramp.
      send(17'h00000);
      tick_exp(lim - 17'h00080, 1'b0, 1'b0);
      cmd   = 17'h00300;
      valid = 1'b1;
      rst   = 1'b1;
      cyc();
      rst   = 1'b0;
      valid = 1'b0;
      #1;
      check("midreset_w", 32'(w), 32'd0);
      check("midreset_settled", 32'(settled), 32'd1);
      check("midreset_wdog", 32'(wdog), 32'd0);
      tick_exp(17'h00000, 1'b1, 1'b0);

      repeat (3) cyc();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
